vend_port_arbiter: RTL and testbench
====================================

Name: vend_port_arbiter

Overview:
- Controller that shares one vending core (2-bit coin input `in`, registered `out` dispense strobe, 2-bit `change`) between NUM_PORTS customer coin ports.
- Round-robin grants one port at a time and forwards that port's coins to the core, one coin per handshake.
- Routes the dispense/change result back to the owning port.
- Tracks stock, aborts and refunds stalled transactions, and holds the core in reset while the controller is in reset.

Parameters:
NUM_PORTS, 4, number of customer ports (>=2); PW = clog2(NUM_PORTS)
STOCK_INIT, 8, item count loaded at reset and on restock (1..255)
TIMEOUT, 15, idle cycles allowed in OWN before abort (1..255)
CORE_LAT, 1, cycles from core_in presentation to valid core_out/core_change (1..3)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
req  input  NUM_PORTS  per-port request; held high for the whole transaction
coin  input  2*NUM_PORTS  per-port coin code, port i at [2i+1:2i]; 00 none, 01 = 5, 10 = 10, 11 invalid
coin_ack  output  NUM_PORTS  one-cycle pulse: coin of that port accepted
gnt  output  NUM_PORTS  one-hot current owner, all-zero when none
core_in  output  2  coin code to the vending core
core_rst  output  1  reset to the vending core
core_out  input  1  core dispense strobe
core_change  input  2  core change code, same encoding as coin
vend_done  output  1  one-cycle pulse: item dispensed
abort  output  1  one-cycle pulse: transaction aborted
res_port  output  PW  owner index, valid with vend_done/abort
res_amt  output  2  change on vend_done, refund on abort; 01 = 5, 10 = 10
stock  output  8  items remaining
sold_out  output  1  stock == 0
restock  input  1  pulse: reload stock to STOCK_INIT

Behaviour:
- Reset values: gnt=0, coin_ack=0, core_in=00, core_rst=1, vend_done=0, abort=0, res_port=0, res_amt=00, stock=STOCK_INIT, sold_out=0, last_owner=NUM_PORTS-1, credit=0, state IDLE.
- core_rst is registered. It stays 1 while rst is asserted and deasserts on the first clk edge after rst is released.
- All other outputs are registered.
- States: IDLE, OWN, WAIT, DONE, ABRT.
- IDLE:
  - If a restock is pending, apply it here: stock=STOCK_INIT, clear the pending flag.
  - If stock==0, no grant is issued.
  - Otherwise, if any req is high, select the first requesting port in the order last_owner+1, +2, ... (wrap-around). Set gnt one-hot to that port next cycle, clear the timeout counter, go to OWN.
- OWN:
  - If req[owner]=0: go to ABRT.
  - Else if coin[owner] is 01 or 10:
    - Pulse coin_ack[owner] and drive core_in=coin for exactly one cycle.
    - credit += 5 or 10 (6-bit).
    - Go to WAIT.
  - Else if the coin is 00 or 11 (11 is never acked or forwarded): increment the timeout counter. When the counter reaches TIMEOUT, go to ABRT.
  - Only the owner's coin is sampled; other ports see coin_ack=0.
- WAIT:
  - core_in=00. Stay CORE_LAT cycles, then sample core_out/core_change.
  - If core_out=1: capture the change and go to DONE.
  - Else: go to OWN with the timeout counter cleared.
- DONE (1 cycle):
  - vend_done=1, res_port=owner, res_amt=captured change.
  - stock -= 1 (saturating at 0), credit=0, last_owner=owner, gnt=0.
  - Go to IDLE.
- ABRT (1 cycle):
  - abort=1, res_port=owner, res_amt=credit code (0→00, 5→01, 10→10), core_rst=1 for this single cycle.
  - credit=0, last_owner=owner, gnt=0.
  - Go to IDLE.
- Credit rule: if a forwarded coin would bring credit above 10 and core_out stays 0, the controller treats it as a core fault: abort with res_amt=10.
- Restock:
  - Sets a pending flag in any state; it is applied in IDLE only.
  - If restock coincides with DONE, the decrement happens first, then the reload in IDLE; net stock = STOCK_INIT.
- Stock reaching 0 does not affect an in-flight transaction. New grants are suppressed until restock.
- Asynchronous reset mid-transaction: everything returns to reset values immediately. No vend_done/abort pulse, no refund reported.
- A req from a non-owner is ignored until return to IDLE. req may drop and reassert freely while not owner.

Test Plan:
- Reset, then req[0]=1 with coin 01 three times (core asserts out after the third, change 00) → three coin_ack[0] pulses; core_in=01 one cycle each; vend_done with res_port=0, res_amt=00; stock 8→7.
- req[1] with coins 10, 10 (core out=1, change=01) → vend_done, res_port=1, res_amt=01, gnt=0 the following cycle.
- req[0] and req[2] both high from IDLE after last_owner=0 → gnt=0100 first; port 0 is granted only after port 2 completes.
- Owner inserts 01, then idles 15 cycles → abort with res_amt=01, core_rst high for 1 cycle, credit cleared; owner drops req mid-transaction → immediate abort.
- STOCK_INIT=1: one vend → stock=0, sold_out=1, later req gets no grant; restock pulse during sold-out → stock=1, grant resumes in IDLE.
- rst asserted during WAIT → gnt=0, core_rst=1, core_in=00 immediately; after release, core_rst=0 on the next edge and arbitration restarts from port 0.

Source files
------------

// File: rtl/vend_port_arbiter.sv
// rtl/vend_port_arbiter.sv - round-robin arbiter sharing one vending core between coin ports
module vend_port_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int STOCK_INIT = 8,
  parameter int TIMEOUT    = 15,
  parameter int CORE_LAT   = 1,
  parameter int PW         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_PORTS-1:0]   req,
  input  logic [2*NUM_PORTS-1:0] coin,
  output logic [NUM_PORTS-1:0]   coin_ack,
  output logic [NUM_PORTS-1:0]   gnt,
  output logic [1:0]             core_in,
  output logic                   core_rst,
  input  logic                   core_out,
  input  logic [1:0]             core_change,
  output logic                   vend_done,
  output logic                   abort,
  output logic [PW-1:0]          res_port,
  output logic [1:0]             res_amt,
  output logic [7:0]             stock,
  output logic                   sold_out,
  input  logic                   restock
);

  typedef enum logic [2:0] {IDLE, OWN, WAIT, DONE, ABRT} state_t;

  localparam logic [NUM_PORTS-1:0] ONE = NUM_PORTS'(1);

  state_t        state;
  logic [PW-1:0] owner;
  logic [PW-1:0] last_owner;
  logic [5:0]    credit;
  logic [7:0]    tcnt;
  logic [1:0]    wcnt;
  logic [1:0]    chg;
  logic          restock_pend;

  logic [PW-1:0] next_owner;
  logic [PW-1:0] cand;
  logic          found;
  logic [1:0]    ocoin;
  logic          oreq;
  logic          pend_eff;
  logic [7:0]    stock_eff;

  // First requester after last_owner, wrapping around.
  always_comb begin
    found      = 1'b0;
    next_owner = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = PW'((int'(last_owner) + k) % NUM_PORTS);
      if (!found && req[cand]) begin
        found      = 1'b1;
        next_owner = cand;
      end
    end
  end

  always_comb begin
    ocoin = 2'b00;
    oreq  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (owner == PW'(i)) begin
        ocoin = coin[2*i +: 2];
        oreq  = req[i];
      end
    end
  end

  // A restock arriving in the IDLE cycle itself is honoured immediately.
  assign pend_eff  = restock_pend | restock;
  assign stock_eff = pend_eff ? 8'(STOCK_INIT) : stock;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= '0;
      last_owner   <= PW'(NUM_PORTS - 1);
      credit       <= '0;
      tcnt         <= '0;
      wcnt         <= '0;
      chg          <= 2'b00;
      restock_pend <= 1'b0;
      gnt          <= '0;
      coin_ack     <= '0;
      core_in      <= 2'b00;
      core_rst     <= 1'b1;
      vend_done    <= 1'b0;
      abort        <= 1'b0;
      res_port     <= '0;
      res_amt      <= 2'b00;
      stock        <= 8'(STOCK_INIT);
      sold_out     <= 1'b0;
    end else begin
      coin_ack  <= '0;
      core_in   <= 2'b00;
      core_rst  <= 1'b0;
      vend_done <= 1'b0;
      abort     <= 1'b0;
      if (restock)
        restock_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (pend_eff) begin
            stock        <= 8'(STOCK_INIT);
            sold_out     <= 1'b0;
            restock_pend <= 1'b0;
          end
          if (stock_eff != 8'd0 && found) begin
            owner <= next_owner;
            gnt   <= ONE << next_owner;
            tcnt  <= '0;
            state <= OWN;
          end
        end

        OWN: begin
          if (!oreq) begin
            state <= ABRT;
          end else if (ocoin == 2'b01 || ocoin == 2'b10) begin
            coin_ack <= ONE << owner;
            core_in  <= ocoin;
            credit   <= credit + ((ocoin == 2'b01) ? 6'd5 : 6'd10);
            wcnt     <= '0;
            state    <= WAIT;
          end else if (tcnt + 8'd1 == 8'(TIMEOUT)) begin
            state <= ABRT;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end

        WAIT: begin
          if (wcnt == 2'(CORE_LAT)) begin
            if (core_out) begin
              chg   <= core_change;
              state <= DONE;
            end else if (credit > 6'd10) begin
              // Core should have vended by now; treat as a fault and refund.
              state <= ABRT;
            end else begin
              tcnt  <= '0;
              state <= OWN;
            end
          end else begin
            wcnt <= wcnt + 2'd1;
          end
        end

        DONE: begin
          vend_done  <= 1'b1;
          res_port   <= owner;
          res_amt    <= chg;
          stock      <= (stock != 8'd0) ? stock - 8'd1 : 8'd0;
          sold_out   <= (stock <= 8'd1);
          credit     <= '0;
          last_owner <= owner;
          gnt        <= '0;
          state      <= IDLE;
        end

        ABRT: begin
          abort      <= 1'b1;
          res_port   <= owner;
          res_amt    <= (credit == 6'd0) ? 2'b00 : (credit == 6'd5) ? 2'b01 : 2'b10;
          core_rst   <= 1'b1;
          credit     <= '0;
          last_owner <= owner;
          gnt        <= '0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_port_arbiter.sv
// tb/tb_vend_port_arbiter.sv - scoreboard bench for vend_port_arbiter with a behavioural vending core
module tb_vend_port_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [7:0] coin = '0;
  logic       restock = 1'b0;
  logic       core_out = 1'b0;
  logic [1:0] core_change = 2'b00;
  logic [3:0] coin_ack;
  logic [3:0] gnt;
  logic [1:0] core_in;
  logic       core_rst;
  logic       vend_done;
  logic       abort;
  logic [1:0] res_port;
  logic [1:0] res_amt;
  logic [7:0] stock;
  logic       sold_out;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  vend_port_arbiter #(
    .NUM_PORTS(4), .STOCK_INIT(8), .TIMEOUT(15), .CORE_LAT(1)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .coin(coin), .coin_ack(coin_ack),
    .gnt(gnt), .core_in(core_in), .core_rst(core_rst), .core_out(core_out),
    .core_change(core_change), .vend_done(vend_done), .abort(abort),
    .res_port(res_port), .res_amt(res_amt), .stock(stock), .sold_out(sold_out),
    .restock(restock)
  );

  // Vending core: 15 buys an item, excess returned as change; core_dead never vends.
  logic [5:0] core_sum = '0;
  logic       core_dead = 1'b0;

  function automatic logic [1:0] enc(input int amt);
    return (amt == 0) ? 2'b00 : (amt == 5) ? 2'b01 : 2'b10;
  endfunction

  always @(posedge clk) begin
    if (core_rst) begin
      core_sum    <= '0;
      core_out    <= 1'b0;
      core_change <= 2'b00;
    end else if (core_in == 2'b01 || core_in == 2'b10) begin
      if (core_dead) begin
        core_out <= 1'b0;
      end else if (int'(core_sum) + ((core_in == 2'b01) ? 5 : 10) >= 15) begin
        core_out    <= 1'b1;
        core_change <= enc(int'(core_sum) + ((core_in == 2'b01) ? 5 : 10) - 15);
        core_sum    <= '0;
      end else begin
        core_out <= 1'b0;
        core_sum <= core_sum + ((core_in == 2'b01) ? 6'd5 : 6'd10);
      end
    end else begin
      core_out <= 1'b0;
    end
  end

  typedef struct {
    logic       vend;
    logic [1:0] port;
    logic [1:0] amt;
  } res_t;

  res_t exp_q[$];
  res_t mon_e;

  always @(negedge clk) begin
    if (!rst && (vend_done || abort)) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL result_unexpected: got vend=%0b abort=%0b port=%0d amt=%b, want no result",
                 vend_done, abort, res_port, res_amt);
      end else begin
        mon_e = exp_q.pop_front();
        if ({vend_done, abort, res_port, res_amt} !== {mon_e.vend, !mon_e.vend, mon_e.port, mon_e.amt})
          $display("FAIL result: got vend=%0b abort=%0b port=%0d amt=%b, want vend=%0b abort=%0b port=%0d amt=%b",
                   vend_done, abort, res_port, res_amt, mon_e.vend, !mon_e.vend, mon_e.port, mon_e.amt);
        else
          passed++;
      end
    end
  end

  task automatic expect_res(input logic v, input logic [1:0] p, input logic [1:0] a);
    res_t r;
    r.vend = v; r.port = p; r.amt = a;
    exp_q.push_back(r);
  endtask

  task automatic wait_gnt(input logic [3:0] e, input int lim);
    int n = 0;
    do begin @(negedge clk); n++; end while (gnt !== e && n < lim);
    total++;
    if (gnt !== e) $display("FAIL gnt_wait: got %b want %b", gnt, e);
    else passed++;
  endtask

  task automatic insert_coin(input int p, input logic [1:0] c);
    int n = 0;
    coin[2*p +: 2] = c;
    do begin @(negedge clk); n++; end while (coin_ack[p] !== 1'b1 && n < 60);
    total++;
    if (coin_ack !== (4'b0001 << p) || core_in !== c)
      $display("FAIL coin_ack: port %0d got ack=%b core_in=%b want ack=%b core_in=%b",
               p, coin_ack, core_in, 4'b0001 << p, c);
    else
      passed++;
    coin[2*p +: 2] = 2'b00;
  endtask

  task automatic wait_result(input int lim, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!(vend_done || abort) && n < lim);
    if (!(vend_done || abort)) begin
      total++;
      $display("FAIL result_timeout: got no result after %0d cycles, want vend_done or abort", n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({gnt, coin_ack, core_in, core_rst, vend_done, abort, res_port, res_amt} !== 18'b0000_0000_00_1_0_0_00_00)
      $display("FAIL reset_outputs: got gnt=%b ack=%b core_in=%b core_rst=%b vd=%b ab=%b port=%0d amt=%b want zeros with core_rst=1",
               gnt, coin_ack, core_in, core_rst, vend_done, abort, res_port, res_amt);
    else passed++;
    total++;
    if (stock !== 8'd8 || sold_out !== 1'b0)
      $display("FAIL reset_stock: got stock=%0d sold_out=%b want 8 0", stock, sold_out);
    else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (core_rst !== 1'b0) $display("FAIL core_rst_release: got %b want 0", core_rst);
    else passed++;
  endtask

  task automatic test_vend_port0();
    int n;
    req[0] = 1'b1;
    expect_res(1'b1, 2'd0, 2'b00);
    wait_gnt(4'b0001, 5);
    insert_coin(0, 2'b01);
    @(negedge clk);
    total++;
    if (core_in !== 2'b00 || coin_ack !== 4'b0000)
      $display("FAIL core_in_one_cycle: got core_in=%b ack=%b want 00 0000", core_in, coin_ack);
    else passed++;
    insert_coin(0, 2'b01);
    insert_coin(0, 2'b01);
    wait_result(10, n);
    req[0] = 1'b0;
    total++;
    if (stock !== 8'd7) $display("FAIL stock_after_vend: got %0d want 7", stock);
    else passed++;
  endtask

  task automatic test_round_robin();
    int n;
    req = 4'b0101;
    expect_res(1'b1, 2'd2, 2'b00);
    wait_gnt(4'b0100, 5);
    insert_coin(2, 2'b10);
    insert_coin(2, 2'b01);
    wait_result(10, n);
    req[2] = 1'b0;
    expect_res(1'b1, 2'd0, 2'b01);
    wait_gnt(4'b0001, 5);
    insert_coin(0, 2'b10);
    insert_coin(0, 2'b10);
    wait_result(10, n);
    req[0] = 1'b0;
    total++;
    if (stock !== 8'd5) $display("FAIL stock_after_rr: got %0d want 5", stock);
    else passed++;
  endtask

  task automatic test_port1_change();
    int n;
    req[1] = 1'b1;
    expect_res(1'b1, 2'd1, 2'b01);
    wait_gnt(4'b0010, 5);
    insert_coin(1, 2'b10);
    insert_coin(1, 2'b10);
    wait_result(10, n);
    req[1] = 1'b0;
    @(negedge clk);
    total++;
    if (gnt !== 4'b0000 || stock !== 8'd4)
      $display("FAIL gnt_after_vend: got gnt=%b stock=%0d want 0000 4", gnt, stock);
    else passed++;
  endtask

  task automatic test_timeout_abort();
    int n = 0;
    logic ack_seen = 1'b0;
    req[3] = 1'b1;
    expect_res(1'b0, 2'd3, 2'b01);
    wait_gnt(4'b1000, 5);
    insert_coin(3, 2'b01);
    coin[7:6] = 2'b11;
    do begin
      @(negedge clk); n++;
      if (coin_ack !== 4'b0000) ack_seen = 1'b1;
    end while (abort !== 1'b1 && n < 40);
    total++;
    if (n !== 18) $display("FAIL timeout_latency: got %0d cycles want 18", n);
    else passed++;
    total++;
    if (ack_seen !== 1'b0 || core_rst !== 1'b1)
      $display("FAIL timeout_abort: got ack_seen=%b core_rst=%b want 0 1", ack_seen, core_rst);
    else passed++;
    coin[7:6] = 2'b00;
    req[3] = 1'b0;
    @(negedge clk);
    total++;
    if (core_rst !== 1'b0 || stock !== 8'd4)
      $display("FAIL core_rst_pulse: got core_rst=%b stock=%0d want 0 4", core_rst, stock);
    else passed++;

    req[0] = 1'b1;
    expect_res(1'b0, 2'd0, 2'b10);
    wait_gnt(4'b0001, 5);
    insert_coin(0, 2'b10);
    repeat (3) @(negedge clk);
    req[0] = 1'b0;
    wait_result(10, n);
    total++;
    if (n !== 2) $display("FAIL drop_abort_latency: got %0d cycles want 2", n);
    else passed++;
  endtask

  task automatic test_credit_fault();
    int n;
    core_dead = 1'b1;
    req[1] = 1'b1;
    expect_res(1'b0, 2'd1, 2'b10);
    wait_gnt(4'b0010, 5);
    insert_coin(1, 2'b10);
    insert_coin(1, 2'b01);
    wait_result(10, n);
    req[1] = 1'b0;
    core_dead = 1'b0;
  endtask

  task automatic test_sold_out();
    int n;
    for (int i = 0; i < 4; i++) begin
      req[2] = 1'b1;
      expect_res(1'b1, 2'd2, 2'b00);
      wait_gnt(4'b0100, 5);
      insert_coin(2, 2'b10);
      insert_coin(2, 2'b01);
      wait_result(10, n);
      req[2] = 1'b0;
    end
    total++;
    if (stock !== 8'd0 || sold_out !== 1'b1)
      $display("FAIL sold_out: got stock=%0d sold_out=%b want 0 1", stock, sold_out);
    else passed++;
    req[0] = 1'b1;
    repeat (8) @(negedge clk);
    total++;
    if (gnt !== 4'b0000) $display("FAIL no_grant_sold_out: got %b want 0000", gnt);
    else passed++;
    restock = 1'b1;
    @(negedge clk);
    restock = 1'b0;
    expect_res(1'b0, 2'd0, 2'b00);
    wait_gnt(4'b0001, 5);
    total++;
    if (stock !== 8'd8 || sold_out !== 1'b0)
      $display("FAIL restock: got stock=%0d sold_out=%b want 8 0", stock, sold_out);
    else passed++;
    req[0] = 1'b0;
    wait_result(10, n);
  endtask

  task automatic test_reset_wait();
    int n;
    req[1] = 1'b1;
    wait_gnt(4'b0010, 5);
    insert_coin(1, 2'b01);
    rst = 1'b1;
    #1;
    total++;
    if ({gnt, core_rst, core_in, coin_ack, vend_done, abort} !== 13'b0000_1_00_0000_0_0)
      $display("FAIL async_reset: got gnt=%b core_rst=%b core_in=%b ack=%b vd=%b ab=%b want 0000 1 00 0000 0 0",
               gnt, core_rst, core_in, coin_ack, vend_done, abort);
    else passed++;
    @(negedge clk);
    #2 rst = 1'b0;
    req = 4'b0011;
    @(posedge clk); #1;
    total++;
    if (core_rst !== 1'b0) $display("FAIL core_rst_after_reset: got %b want 0", core_rst);
    else passed++;
    wait_gnt(4'b0001, 5);
    expect_res(1'b0, 2'd0, 2'b00);
    req = 4'b0000;
    wait_result(10, n);
  endtask

  initial begin
    test_reset();
    test_vend_port0();
    test_round_robin();
    test_port1_change();
    test_timeout_abort();
    test_credit_fault();
    test_sold_out();
    test_reset_wait();
    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
